// File: rtl/hero_write_rx.sv
// Receive side of the hero write bus: frames beats into transactions by cycle_type,
// buffers them in a FIFO and presents them to a local consumer with a last marker.
module hero_write_rx #(
  parameter int DEPTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [45:0] hero_in,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [35:0] out_wdat,
  output logic [6:0]  out_sub,
  output logic        out_last,
  output logic        in_txn,
  output logic [15:0] txn_cnt,
  output logic        err_overflow,
  output logic        err_too_long
);

  localparam int DATA_W = 36;
  localparam int SUB_W  = 7;
  localparam int ENT_W  = DATA_W + SUB_W + 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BCNT_W = $clog2(MAX_BEATS + 1);

  localparam logic [1:0] CT_IDLE = 2'd0;
  localparam logic [1:0] CT_DONE = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IN_TXN = 2'd1;
  localparam logic [1:0] ST_DROP   = 2'd2;

  // hero_write_t layout: {cycle_type[1:0], wdat[35:0], another_type_reference[6:0], clk_en}
  logic [1:0]        cycle_type;
  logic [DATA_W-1:0] beat_wdat;
  logic [SUB_W-1:0]  beat_sub;
  logic              clk_en;

  assign cycle_type = hero_in[45:44];
  assign beat_wdat  = hero_in[43:8];
  assign beat_sub   = hero_in[7:1];
  assign clk_en     = hero_in[0];

  logic qual;
  logic is_done;
  assign qual    = clk_en && (cycle_type != CT_IDLE);
  assign is_done = (cycle_type == CT_DONE);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [BCNT_W-1:0] bcnt;
  logic [BCNT_W-1:0] bcnt_nx;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              push_en;
  logic              push_last;
  logic              pop_en;
  logic              set_overflow;
  logic              set_too_long;
  logic [ENT_W-1:0]  head;

  assign full   = (count == CNT_W'(DEPTH));
  assign pop_en = out_vld && out_rdy;

  always_comb begin
    state_nx     = state;
    bcnt_nx      = bcnt;
    push_en      = 1'b0;
    push_last    = 1'b0;
    set_overflow = 1'b0;
    set_too_long = 1'b0;
    if (qual) begin
      case (state)
        ST_IDLE: begin
          push_en = 1'b1;
          if (is_done) begin
            push_last = 1'b1;
          end else if (MAX_BEATS == 1) begin
            push_last    = 1'b1;
            set_too_long = 1'b1;
            state_nx     = ST_DROP;
          end else begin
            bcnt_nx  = BCNT_W'(1);
            state_nx = ST_IN_TXN;
          end
        end
        ST_IN_TXN: begin
          push_en = 1'b1;
          if (is_done) begin
            push_last = 1'b1;
            bcnt_nx   = '0;
            state_nx  = ST_IDLE;
          end else if (bcnt == BCNT_W'(MAX_BEATS - 1)) begin
            push_last    = 1'b1;
            set_too_long = 1'b1;
            bcnt_nx      = '0;
            state_nx     = ST_DROP;
          end else begin
            bcnt_nx = bcnt + BCNT_W'(1);
          end
        end
        ST_DROP: begin
          if (is_done) state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
      // Full is judged on the pre-edge count; a same-cycle pop does not make room.
      if (push_en && full) begin
        push_en      = 1'b0;
        push_last    = 1'b0;
        set_overflow = 1'b1;
        bcnt_nx      = '0;
        state_nx     = is_done ? ST_IDLE : ST_DROP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bcnt         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      txn_cnt      <= '0;
      err_overflow <= 1'b0;
      err_too_long <= 1'b0;
    end else begin
      state <= state_nx;
      bcnt  <= bcnt_nx;
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push_en && push_last) txn_cnt <= txn_cnt + 16'd1;
      if (set_overflow) err_overflow <= 1'b1;
      if (set_too_long) err_too_long <= 1'b1;
    end
  end

  // Storage carries data only; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= {push_last, beat_wdat, beat_sub};
  end

  assign head     = mem[rd_ptr];
  assign out_vld  = (count != '0);
  assign out_last = out_vld ? head[ENT_W-1] : 1'b0;
  assign out_wdat = out_vld ? head[ENT_W-2:SUB_W] : '0;
  assign out_sub  = out_vld ? head[SUB_W-1:0] : '0;
  assign in_txn   = (state == ST_IN_TXN);

endmodule
